// File: rtl/echo_capture_buffer.sv
// Echo capture buffer: records one decimated A-scan per transmit trigger, tracks its peak,
// then presents the stored words to the ARM read-FIFO port until the ARM signals read-over.
module echo_capture_buffer #(
    parameter int DATA_W      = 10,
    parameter int ADDR_W      = 10,
    parameter int CAPTURE_LEN = 1000
) (
    input  logic              clk_sys,
    input  logic              RESET,
    input  logic [DATA_W-1:0] AD_data,
    input  logic              AD_valid,
    input  logic              trigger,
    input  logic [1:0]        AD_sample_flag,
    input  logic              ARM_read_fifo_rdreq,
    input  logic              ARM_read_over,
    output logic [DATA_W-1:0] ARM_read_fifo_data,
    output logic [DATA_W-1:0] ARM_MAX_data,
    output logic              ARM_data_ready
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        READY   = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(CAPTURE_LEN - 1);

    state_t            state_q, state_d;
    logic [1:0]        flag_q, flag_d;
    logic [2:0]        dec_cnt_q, dec_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] max_run_q, max_run_d;
    logic [DATA_W-1:0] arm_max_q, arm_max_d;
    logic              settle_q, settle_d;
    logic              ready_q, ready_d;
    logic              pop_q, pop_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              sync3_q, sync3_d;
    logic [DATA_W-1:0] rd_data_q;

    logic [DATA_W-1:0] mem [0:(1 << ADDR_W) - 1];

    logic              read_over_pulse;
    logic              mem_we;
    logic              last_write;
    logic              rd_load;
    logic [2:0]        dec_mask;

    assign read_over_pulse = sync2_q & ~sync3_q;
    assign mem_we          = (state_q == CAPTURE) && AD_valid && (dec_cnt_q == 3'd0);
    assign last_write      = mem_we && (wr_ptr_q == LAST_IDX);
    // One settle cycle after entering READY lets word 0 and the ready flag appear together.
    assign rd_load         = (state_q == READY) && settle_q;
    assign dec_mask        = 3'((4'd1 << flag_q) - 4'd1);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            state_q   <= IDLE;
            flag_q    <= 2'd0;
            dec_cnt_q <= 3'd0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            max_run_q <= '0;
            arm_max_q <= '0;
            settle_q  <= 1'b0;
            ready_q   <= 1'b0;
            pop_q     <= 1'b0;
            sync1_q   <= 1'b0;
            sync2_q   <= 1'b0;
            sync3_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            flag_q    <= flag_d;
            dec_cnt_q <= dec_cnt_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            max_run_q <= max_run_d;
            arm_max_q <= arm_max_d;
            settle_q  <= settle_d;
            ready_q   <= ready_d;
            pop_q     <= pop_d;
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            sync3_q   <= sync3_d;
        end
    end

    // NOTE: the storage array has no reset; its contents are only read after a full capture.
    always_ff @(posedge clk_sys) begin
        if (mem_we) begin
            mem[wr_ptr_q] <= AD_data;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (RESET) begin
            rd_data_q <= '0;
        end else if (rd_load) begin
            rd_data_q <= mem[rd_ptr_q];
        end
    end

    // NOTE: every combinational output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (trigger)         state_d = CAPTURE;
            CAPTURE: if (last_write)      state_d = READY;
            READY:   if (read_over_pulse) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    always_comb begin
        flag_d    = flag_q;
        dec_cnt_d = dec_cnt_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        max_run_d = max_run_q;
        arm_max_d = arm_max_q;
        sync1_d   = ARM_read_over;
        sync2_d   = sync1_q;
        sync3_d   = sync2_q;
        settle_d  = (state_q == READY) && !read_over_pulse;
        ready_d   = rd_load && !read_over_pulse;
        pop_d     = ARM_read_fifo_rdreq && ready_q && !read_over_pulse;

        if (state_q == IDLE && trigger) begin
            flag_d    = AD_sample_flag;
            dec_cnt_d = 3'd0;
            wr_ptr_d  = '0;
            max_run_d = '0;
        end

        if (state_q == CAPTURE) begin
            rd_ptr_d = '0;
            if (AD_valid) begin
                dec_cnt_d = (dec_cnt_q + 3'd1) & dec_mask;
            end
            if (mem_we) begin
                wr_ptr_d = wr_ptr_q + 1'b1;
                if (AD_data > max_run_q) begin
                    max_run_d = AD_data;
                end
                if (last_write) begin
                    arm_max_d = max_run_d;
                end
            end
        end

        // The read pointer saturates on the last word: no wrap-around.
        if (state_q == READY && pop_q && rd_ptr_q != LAST_IDX) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    assign ARM_read_fifo_data = rd_data_q;
    assign ARM_MAX_data       = arm_max_q;
    assign ARM_data_ready     = ready_q;

endmodule

// File: tb/tb_echo_capture_buffer.sv
// Directed self-checking bench for echo_capture_buffer with an 8-word capture filling a
// 3-bit address space, so the full-depth boundary is exercised too.
module tb_echo_capture_buffer;

    localparam int DATA_W = 10;
    localparam int ADDR_W = 3;
    localparam int LEN    = 8;

    logic              clk_sys = 1'b0;
    logic              RESET;
    logic [DATA_W-1:0] AD_data;
    logic              AD_valid;
    logic              trigger;
    logic [1:0]        AD_sample_flag;
    logic              ARM_read_fifo_rdreq;
    logic              ARM_read_over;
    logic [DATA_W-1:0] ARM_read_fifo_data;
    logic [DATA_W-1:0] ARM_MAX_data;
    logic              ARM_data_ready;

    int checks = 0;
    int errors = 0;

    echo_capture_buffer #(
        .DATA_W     (DATA_W),
        .ADDR_W     (ADDR_W),
        .CAPTURE_LEN(LEN)
    ) dut (
        .clk_sys            (clk_sys),
        .RESET              (RESET),
        .AD_data            (AD_data),
        .AD_valid           (AD_valid),
        .trigger            (trigger),
        .AD_sample_flag     (AD_sample_flag),
        .ARM_read_fifo_rdreq(ARM_read_fifo_rdreq),
        .ARM_read_over      (ARM_read_over),
        .ARM_read_fifo_data (ARM_read_fifo_data),
        .ARM_MAX_data       (ARM_MAX_data),
        .ARM_data_ready     (ARM_data_ready)
    );

    always #5 clk_sys = ~clk_sys;

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic start_capture(input logic [1:0] flag);
        trigger        = 1'b1;
        AD_sample_flag = flag;
        step();
        trigger        = 1'b0;
    endtask

    task automatic sample(input logic [DATA_W-1:0] d, input logic v);
        AD_data  = d;
        AD_valid = v;
        step();
        AD_valid = 1'b0;
    endtask

    task automatic pop_and_check(input string tag, input logic [DATA_W-1:0] expected);
        ARM_read_fifo_rdreq = 1'b1;
        step();
        ARM_read_fifo_rdreq = 1'b0;
        step(2);
        check(tag, 32'(ARM_read_fifo_data), 32'(expected));
    endtask

    // Asynchronous rise of read-over; the ready flag must be gone within 4 clk_sys edges.
    task automatic raise_read_over(input string tag);
        #3 ARM_read_over = 1'b1;
        step(4);
        check(tag, 32'(ARM_data_ready), 32'd0);
    endtask

    initial begin
        RESET               = 1'b1;
        AD_data             = '0;
        AD_valid            = 1'b0;
        trigger             = 1'b0;
        AD_sample_flag      = 2'd0;
        ARM_read_fifo_rdreq = 1'b0;
        ARM_read_over       = 1'b0;
        step(2);
        RESET = 1'b0;
        check("reset_ready", 32'(ARM_data_ready), 32'd0);
        check("reset_data", 32'(ARM_read_fifo_data), 32'd0);
        check("reset_max", 32'(ARM_MAX_data), 32'd0);

        // Capture 1: undecimated ramp 1..8, continuous valid.
        start_capture(2'd0);
        AD_valid = 1'b1;
        for (int i = 1; i <= LEN; i++) begin
            AD_data = DATA_W'(i);
            step();
        end
        AD_valid = 1'b0;
        check("c1_ready_at_n", 32'(ARM_data_ready), 32'd0);
        check("c1_max_at_n", 32'(ARM_MAX_data), 32'd8);
        step();
        check("c1_ready_at_n1", 32'(ARM_data_ready), 32'd0);
        step();
        check("c1_ready_at_n2", 32'(ARM_data_ready), 32'd1);
        check("c1_word0", 32'(ARM_read_fifo_data), 32'd1);
        for (int k = 1; k <= LEN; k++) begin
            pop_and_check($sformatf("c1_pop%0d", k), DATA_W'((k + 1 > LEN) ? LEN : k + 1));
        end

        // Trigger and extra pops in READY are ignored.
        trigger  = 1'b1;
        AD_valid = 1'b1;
        AD_data  = 10'h3FF;
        step();
        trigger = 1'b0;
        step(3);
        AD_valid = 1'b0;
        pop_and_check("c1_pop_beyond_a", 10'd8);
        pop_and_check("c1_pop_beyond_b", 10'd8);
        check("c1_ready_hold", 32'(ARM_data_ready), 32'd1);
        check("c1_max_hold", 32'(ARM_MAX_data), 32'd8);

        raise_read_over("c1_exit");
        check("c1_data_not_cleared", 32'(ARM_read_fifo_data), 32'd8);
        check("c1_max_after_exit", 32'(ARM_MAX_data), 32'd8);

        // Capture 2: keep 1 of 4, valid toggling, read-over held high throughout.
        start_capture(2'd2);
        for (int i = 0; i < 32; i++) begin
            sample(DATA_W'(i), 1'b1);
            sample(10'h3FF, 1'b0);
        end
        step(2);
        check("c2_ready", 32'(ARM_data_ready), 32'd1);
        check("c2_max", 32'(ARM_MAX_data), 32'd28);
        check("c2_word0", 32'(ARM_read_fifo_data), 32'd0);
        for (int k = 1; k < LEN; k++) begin
            pop_and_check($sformatf("c2_pop%0d", k), DATA_W'(4 * k));
        end
        step(4);
        check("c2_level_no_exit", 32'(ARM_data_ready), 32'd1);
        ARM_read_over = 1'b0;
        step(3);
        check("c2_fall_no_exit", 32'(ARM_data_ready), 32'd1);
        raise_read_over("c2_exit");

        // Capture 3: keep 1 of 2; peak on a kept sample, near-peak on a skipped one.
        start_capture(2'd1);
        AD_valid = 1'b1;
        for (int i = 0; i < 2 * LEN; i++) begin
            AD_data = (i == 4) ? 10'h3FF : (i == 5) ? 10'h3FE : DATA_W'(i);
            step();
        end
        AD_valid = 1'b0;
        step(2);
        check("c3_max_kept_peak", 32'(ARM_MAX_data), 32'h3FF);
        ARM_read_over = 1'b0;
        step(3);
        raise_read_over("c3_exit");

        // Capture 4: peak only on a skipped sample.
        start_capture(2'd1);
        AD_valid = 1'b1;
        for (int i = 0; i < 2 * LEN; i++) begin
            AD_data = (i == 5) ? 10'h3FF : DATA_W'(i);
            step();
        end
        AD_valid = 1'b0;
        step(2);
        check("c4_max_skipped_peak", 32'(ARM_MAX_data), 32'd14);
        check("c4_word0", 32'(ARM_read_fifo_data), 32'd0);
        pop_and_check("c4_pop1", 10'd2);
        pop_and_check("c4_pop2", 10'd4);
        ARM_read_over = 1'b0;
        step(3);
        raise_read_over("c4_exit");
        ARM_read_over = 1'b0;
        step(3);

        // Reset in the middle of a capture, then a clean capture.
        start_capture(2'd0);
        sample(10'd100, 1'b1);
        sample(10'd200, 1'b1);
        sample(10'd300, 1'b1);
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        check("rst_mid_ready", 32'(ARM_data_ready), 32'd0);
        check("rst_mid_data", 32'(ARM_read_fifo_data), 32'd0);
        check("rst_mid_max", 32'(ARM_MAX_data), 32'd0);
        start_capture(2'd0);
        AD_valid = 1'b1;
        for (int i = 0; i < LEN; i++) begin
            case (i)
                0: AD_data = 10'd12;
                1: AD_data = 10'd340;
                2: AD_data = 10'd77;
                3: AD_data = 10'd901;
                4: AD_data = 10'd3;
                5: AD_data = 10'd650;
                6: AD_data = 10'd900;
                default: AD_data = 10'd15;
            endcase
            step();
        end
        AD_valid = 1'b0;
        step(2);
        check("c5_ready", 32'(ARM_data_ready), 32'd1);
        check("c5_word0", 32'(ARM_read_fifo_data), 32'd12);
        check("c5_max", 32'(ARM_MAX_data), 32'd901);

        // Trigger coinciding with the read-over pulse edge is lost.
        #3 ARM_read_over = 1'b1;
        step(2);
        trigger = 1'b1;
        step();
        trigger = 1'b0;
        check("sim_exit_ready", 32'(ARM_data_ready), 32'd0);
        AD_valid = 1'b1;
        AD_data  = 10'd500;
        step(LEN);
        AD_valid = 1'b0;
        step(3);
        check("sim_trigger_lost", 32'(ARM_data_ready), 32'd0);
        check("sim_max_held", 32'(ARM_MAX_data), 32'd901);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/echo_capture_buffer.md
Name: echo_capture_buffer

Overview:
Capture stage directly upstream of the FPGA–ARM register interface. On each transmit trigger it records one decimated A-scan of 10-bit AD samples into an on-chip buffer and tracks the peak amplitude. It then presents the buffer word by word on the ARM read-FIFO port, with a data-ready flag, until the ARM signals read-over. It produces ARM_read_fifo_data, ARM_MAX_data and ARM_data_ready, and consumes ARM_read_fifo_rdreq, ARM_read_over and AD_sample_flag.

Parameters:
DATA_W, 10, sample and buffer word width
ADDR_W, 10, buffer address width (depth 2**ADDR_W)
CAPTURE_LEN, 1000, samples stored per capture; legal range 1..2**ADDR_W

Ports:
clk_sys  input  1  system clock; all logic on its rising edge
RESET  input  1  synchronous, active-high reset
AD_data  input  DATA_W  unsigned AD sample
AD_valid  input  1  AD_data valid this cycle
trigger  input  1  one-cycle pulse at transmit start
AD_sample_flag  input  2  decimation select: 0 keeps 1 of 1, 1 keeps 1 of 2, 2 keeps 1 of 4, 3 keeps 1 of 8 valid samples
ARM_read_fifo_rdreq  input  1  one-cycle pop request, clk_sys domain
ARM_read_over  input  1  level from ARM register write domain; asynchronous
ARM_read_fifo_data  output  DATA_W  current head word of the buffer
ARM_MAX_data  output  DATA_W  peak sample of the last completed capture
ARM_data_ready  output  1  buffer holds a complete capture

Behaviour:
- Reset (RESET=1 at a clk_sys edge): state IDLE; all outputs 0; pointers, decimation counter, running max and synchronizer cleared. Reset applied in any state aborts the operation in progress; buffer contents are don't-care afterwards.
- ARM_read_over: passes through a 2-FF synchronizer, then rising-edge detection gives read_over_pulse. Only rising edges act; a level held high has no further effect.
- State IDLE:
  - trigger=1 latches AD_sample_flag, clears wr_ptr, decimation counter and running max, then moves to CAPTURE.
  - ARM_data_ready stays 0.
- State CAPTURE:
  - Each AD_valid=1 cycle advances the decimation counter. Only the sample where the counter is 0 is written to mem[wr_ptr]; wr_ptr then increments.
  - Cycles with AD_valid=0 are ignored and do not advance the counter.
  - Running max updates only when a written sample is strictly greater (unsigned); unwritten samples are excluded.
  - The write that makes the count equal CAPTURE_LEN moves the block to READY and copies the final max into ARM_MAX_data in the same edge.
  - trigger is ignored in CAPTURE.
- State READY:
  - rd_ptr starts at 0. The buffer uses a registered synchronous read; ARM_read_fifo_data is the registered mem[rd_ptr].
  - If the last write occurs at edge N, then ARM_data_ready=1 and ARM_read_fifo_data=word 0 from edge N+2.
  - ARM_read_fifo_rdreq=1 at edge M advances rd_ptr at M+1; the next word appears at M+2.
  - Once CAPTURE_LEN pops have been accepted, further rdreq are ignored and the output holds the last word. No wrap-around.
  - Pops are counted only while ARM_data_ready=1; rdreq in any other state is ignored.
  - read_over_pulse moves the block to IDLE and drops ARM_data_ready on the next edge, whether or not all words were read.
  - ARM_MAX_data holds its value until the next capture completes.
  - trigger is ignored in READY: no overwrite, no overrun.
- Simultaneous events:
  - trigger together with read_over_pulse in READY: go to IDLE only; that trigger is lost.
  - rdreq together with read_over_pulse: the pop is irrelevant; state goes to IDLE.
- ARM_read_fifo_data is not cleared on leaving READY.

Test Plan:
- Reset, then trigger with AD_sample_flag=0 and CAPTURE_LEN=8, feeding AD_data 1..8 with AD_valid continuous -> ARM_data_ready=1 two cycles after the 8th sample; ARM_MAX_data=8; data reads 1; 8 rdreq pulses step the data 2..8 then hold at 8.
- AD_sample_flag=2, AD_valid toggling 1/0, samples 0..31 -> stored words are 0,4,8,...,28; ARM_MAX_data=28; invalid cycles do not count.
- Peak 0x3FF on an undecimated sample and 0x3FE on a skipped sample with flag=1 -> ARM_MAX_data=0x3FF; with the peak only on the skipped sample -> ARM_MAX_data ≠ that value.
- In READY, apply a second trigger plus rdreq pulses beyond CAPTURE_LEN -> buffer unchanged, output held, ARM_data_ready stays 1; toggle ARM_read_over 0→1 asynchronously -> ARM_data_ready=0 within 4 clk_sys cycles; holding it high gives no second effect.
- Assert RESET mid-CAPTURE after 3 samples, then run a new trigger -> all outputs 0 immediately after reset; the new capture completes normally with the correct max.
- Hold ARM_read_over=1 through a full capture -> no exit from READY until it falls and rises again.
